// File: rtl/serial_chunk_adder_pkg.sv
// Shared types and constants for the chunk-serial adder/subtractor.
package serial_chunk_adder_pkg;

   // FSM encoding, kept as explicit 2-bit values so older code can decode it
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_chunk_adder_add_slice.sv
// CHUNK-bit combinational ripple slice. It also reports the carry into its top
// bit, so the top can derive signed overflow on the final chunk.
module add_slice #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] s,
   output logic         cout,
   output logic         cin_msb
);

   logic [W:0] sum;

   // full-width add with one extra bit to capture the carry out
   always_comb begin
      sum     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      s       = sum[W-1:0];
      cout    = sum[W];
      cin_msb = a[W-1] ^ b[W-1] ^ sum[W-1];
   end

endmodule

// File: rtl/serial_chunk_adder.sv
// Chunk-serial adder/subtractor. It adds CHUNK bits per cycle, starting with
// the least significant chunk, and keeps the carry in a register between chunks.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand set
// RUN   | one chunk added per cycle, chunk index held in cnt
// DONE  | result held, out_valid high until the consumer takes it
module serial_chunk_adder
   import serial_chunk_adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             ovf
);

   localparam int NCHUNK = WIDTH / ((CHUNK < 1) ? 1 : CHUNK);
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

   generate
      if ((CHUNK < 1) || ((WIDTH % ((CHUNK < 1) ? 1 : CHUNK)) != 0)) begin : g_bad_chunk
         $error("serial_chunk_adder: WIDTH must be a positive multiple of CHUNK");
      end
   endgenerate

   state_t           state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] s_q;
   logic             carry;
   logic             co_q;
   logic             ovf_q;
   logic [CW-1:0]    cnt;

   logic [CHUNK-1:0] sl_a;
   logic [CHUNK-1:0] sl_b;
   logic [CHUNK-1:0] sl_s;
   logic             sl_cout;
   logic             sl_cin_msb;

   // select the current chunk of both operands
   always_comb begin
      sl_a = a_q[int'(cnt)*CHUNK +: CHUNK];
      sl_b = b_q[int'(cnt)*CHUNK +: CHUNK];
   end

   add_slice #(.W(CHUNK)) u_slice (
      .a       (sl_a),
      .b       (sl_b),
      .cin     (carry),
      .s       (sl_s),
      .cout    (sl_cout),
      .cin_msb (sl_cin_msb)
   );

   // sequencing and datapath registers: latch on accept, one chunk per RUN cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         a_q   <= '0;
         b_q   <= '0;
         s_q   <= '0;
         carry <= 1'b0;
         co_q  <= 1'b0;
         ovf_q <= 1'b0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q   <= a;
                  b_q   <= (sub == OP_SUB) ? ~b : b;
                  carry <= sub;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               s_q[int'(cnt)*CHUNK +: CHUNK] <= sl_s;
               carry <= sl_cout;
               if (cnt == LAST) begin
                  co_q  <= sl_cout;
                  ovf_q <= sl_cin_msb ^ sl_cout;
                  cnt   <= '0;
                  state <= DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // handshakes are decoded from the state, so reset reaches them immediately
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      s         = s_q;
      co        = co_q;
      ovf       = ovf_q;
   end

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Scoreboard bench for serial_chunk_adder. There are three instances with
// CHUNK = 4, 1 and 16.
module tb_serial_chunk_adder;
   import serial_chunk_adder_pkg::*;

   typedef struct packed {
      logic [15:0] s;
      logic        co;
      logic        ovf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid_v [3];
   logic        sub_v      [3];
   logic        out_ready_v[3];
   logic [15:0] a_v        [3];
   logic [15:0] b_v        [3];
   logic        in_ready_v [3];
   logic        out_valid_v[3];
   logic        co_v       [3];
   logic        ovf_v      [3];
   logic [15:0] s_v        [3];

   int   n_vec = 0;
   int   n_err = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   serial_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
      .a(a_v[0]), .b(b_v[0]), .sub(sub_v[0]), .out_valid(out_valid_v[0]),
      .out_ready(out_ready_v[0]), .s(s_v[0]), .co(co_v[0]), .ovf(ovf_v[0]));

   serial_chunk_adder #(.WIDTH(16), .CHUNK(1)) dut_c1 (
      .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
      .a(a_v[1]), .b(b_v[1]), .sub(sub_v[1]), .out_valid(out_valid_v[1]),
      .out_ready(out_ready_v[1]), .s(s_v[1]), .co(co_v[1]), .ovf(ovf_v[1]));

   serial_chunk_adder #(.WIDTH(16), .CHUNK(16)) dut_c16 (
      .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
      .a(a_v[2]), .b(b_v[2]), .sub(sub_v[2]), .out_valid(out_valid_v[2]),
      .out_ready(out_ready_v[2]), .s(s_v[2]), .co(co_v[2]), .ovf(ovf_v[2]));

   function automatic int nchunk(input int d);
      case (d)
         0:       nchunk = 4;
         1:       nchunk = 16;
         default: nchunk = 1;
      endcase
   endfunction

   function automatic exp_t model(input logic [15:0] aa, input logic [15:0] bb, input logic ss);
      logic [15:0] bx;
      logic [16:0] r;
      bx = (ss == OP_SUB) ? ~bb : bb;
      r  = {1'b0, aa} + {1'b0, bx} + {16'd0, ss};
      model.s   = r[15:0];
      model.co  = r[16];
      model.ovf = (aa[15] == bx[15]) && (r[15] != aa[15]);
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // caller is at a negedge; returns #1 after the edge where out_valid is seen
   task automatic start_op(input int d, input logic [15:0] aa, input logic [15:0] bb,
                           input logic ss, output int lat);
      check_eq("in_ready_before", {31'd0, in_ready_v[d]}, 32'd1);
      a_v[d] = aa; b_v[d] = bb; sub_v[d] = ss; in_valid_v[d] = 1'b1;
      sb.push_back(model(aa, bb, ss));
      @(posedge clk); #1;
      in_valid_v[d] = 1'b0;
      lat = 0;
      while (!out_valid_v[d] && lat < 64) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   // pops the expectation, checks result and latency, then checks the return to IDLE
   task automatic finish_op(input int d, input int lat);
      exp_t e;
      e = '0;
      if (sb.size() > 0) e = sb.pop_front();
      check_eq("latency", lat, nchunk(d));
      check_eq("s",   {16'd0, s_v[d]}, {16'd0, e.s});
      check_eq("co",  {31'd0, co_v[d]},  {31'd0, e.co});
      check_eq("ovf", {31'd0, ovf_v[d]}, {31'd0, e.ovf});
      @(posedge clk); #1;
      check_eq("idle_in_ready",  {31'd0, in_ready_v[d]},  32'd1);
      check_eq("idle_out_valid", {31'd0, out_valid_v[d]}, 32'd0);
      @(negedge clk);
   endtask

   task automatic run_op(input int d, input logic [15:0] aa, input logic [15:0] bb, input logic ss);
      int lat;
      start_op(d, aa, bb, ss, lat);
      finish_op(d, lat);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int lat;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid_v[i] = 1'b0; sub_v[i] = 1'b0; out_ready_v[i] = 1'b1;
         a_v[i] = '0; b_v[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_in_ready",  {31'd0, in_ready_v[0]},  32'd1);
      check_eq("rst_out_valid", {31'd0, out_valid_v[0]}, 32'd0);
      check_eq("rst_s",   {16'd0, s_v[0]},  32'd0);
      check_eq("rst_co",  {31'd0, co_v[0]},  32'd0);
      check_eq("rst_ovf", {31'd0, ovf_v[0]}, 32'd0);

      // release reset and offer an operand on the very first edge
      @(negedge clk);
      rst = 1'b0;
      run_op(0, 16'h00FF, 16'h0001, OP_ADD);
      run_op(0, 16'hFFFF, 16'h0001, OP_ADD);
      run_op(0, 16'h7FFF, 16'h0001, OP_ADD);
      run_op(0, 16'h0005, 16'h0007, OP_SUB);
      run_op(0, 16'h8000, 16'h0001, OP_SUB);
      for (int i = 0; i < 6; i++)
         run_op(0, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));

      // consumer stalls in DONE while new operands are waved at the block
      out_ready_v[0] = 1'b0;
      start_op(0, 16'h1234, 16'h0F0F, OP_SUB, lat);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid_v[0] = 1'b1; a_v[0] = 16'hAAAA; b_v[0] = 16'h5555; sub_v[0] = OP_ADD;
         @(posedge clk); #1;
         check_eq("stall_s",   {16'd0, s_v[0]},  {16'd0, sb[0].s});
         check_eq("stall_co",  {31'd0, co_v[0]},  {31'd0, sb[0].co});
         check_eq("stall_ovf", {31'd0, ovf_v[0]}, {31'd0, sb[0].ovf});
         check_eq("stall_in_ready",  {31'd0, in_ready_v[0]},  32'd0);
         check_eq("stall_out_valid", {31'd0, out_valid_v[0]}, 32'd1);
      end
      in_valid_v[0] = 1'b0;
      out_ready_v[0] = 1'b1;
      finish_op(0, lat);

      // asynchronous reset after two chunks of an operation; it must vanish
      a_v[0] = 16'h1234; b_v[0] = 16'h1111; sub_v[0] = OP_ADD; in_valid_v[0] = 1'b1;
      @(posedge clk); #1;
      in_valid_v[0] = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check_eq("abort_s",         {16'd0, s_v[0]},  32'd0);
      check_eq("abort_co",        {31'd0, co_v[0]},  32'd0);
      check_eq("abort_ovf",       {31'd0, ovf_v[0]}, 32'd0);
      check_eq("abort_in_ready",  {31'd0, in_ready_v[0]},  32'd1);
      check_eq("abort_out_valid", {31'd0, out_valid_v[0]}, 32'd0);
      @(posedge clk); #1;
      check_eq("abort_hold_out_valid", {31'd0, out_valid_v[0]}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run_op(0, 16'h1234, 16'h1111, OP_ADD);

      // single-chunk and bit-serial instances
      run_op(2, 16'hFFFF, 16'h0001, OP_ADD);
      run_op(2, 16'h8000, 16'h0001, OP_SUB);
      run_op(1, 16'hFFFF, 16'h0001, OP_ADD);
      run_op(1, 16'h7FFF, 16'h0001, OP_ADD);
      for (int i = 0; i < 2; i++) begin
         run_op(1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
         run_op(2, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
      end

      check_eq("scoreboard_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/serial_chunk_adder.md
SERIAL_CHUNK_ADDER -- requirements
Module: serial_chunk_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits.
REQ-002 Parameter CHUNK, default 4, bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK, CHUNK >= 1 (elaboration error otherwise).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand set presented.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  WIDTH  operand A, unsigned/two's-complement.
REQ-008 b  input  WIDTH  operand B.
REQ-009 sub  input  1  0 = a+b, 1 = a-b.
REQ-010 out_valid  output  1  result held and valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 s  output  WIDTH  sum/difference, modulo 2^WIDTH.
REQ-013 co  output  1  carry out of bit WIDTH-1 (sub: 1 = no borrow).
REQ-014 ovf  output  1  signed two's-complement overflow.

Function
REQ-015 The block SHALL compute a + (sub ? ~b : b) + sub, CHUNK bits per cycle, LSB chunk first, carry registered between chunks; NCHUNK = WIDTH/CHUNK.
REQ-016 FSM states SHALL be IDLE, RUN, DONE.
REQ-017 IDLE: in_ready=1; on in_valid, the block SHALL latch a, b (inverted if sub) and sub as initial carry, clear chunk counter, and go to RUN.
REQ-018 RUN: in_ready=0, out_valid=0; each cycle SHALL add chunk[cnt] with the stored carry, write s chunk[cnt], and update the carry; after chunk NCHUNK-1 go to DONE.
REQ-019 Latency: acceptance at edge k SHALL give out_valid=1 after edge k+NCHUNK; in_valid/a/b/sub SHALL be ignored outside IDLE.
REQ-020 DONE: out_valid=1; s, co, ovf SHALL stay stable until out_valid&&out_ready, then go to IDLE (in_ready=1 the following cycle).
REQ-021 co SHALL be the final chunk carry; ovf SHALL be carry-into-MSB XOR carry-out-of-MSB.
REQ-022 CHUNK == WIDTH SHALL give NCHUNK=1 (single RUN cycle); counter SHALL be ceil(log2(NCHUNK)) bits, min 1, with no wrap beyond NCHUNK-1.
REQ-023 out_ready held low SHALL stall indefinitely in DONE without corrupting results.

Reset
REQ-024 rst asserted SHALL immediately force state=IDLE, in_ready=1, out_valid=0, s=0, co=0, ovf=0, counter=0, carry=0.
REQ-025 Reset during RUN or DONE SHALL discard the operation; no out_valid SHALL appear for it.
REQ-026 First acceptance after reset release SHALL be possible on the first rising edge with rst low.

Structure
REQ-027 Package serial_chunk_adder_pkg SHALL hold the state enum (IDLE/RUN/DONE) and op constants (OP_ADD=0, OP_SUB=1).
REQ-028 One sub-module, add_slice (CHUNK-bit combinational adder: a, b, cin -> s, cout, cin_msb), SHALL be instantiated once; registers stay in the top.

Verification (WIDTH=16, CHUNK=4)
REQ-029 a=0x00FF, b=0x0001, sub=0 -> out_valid 4 cycles after acceptance, s=0x0100, co=0, ovf=0.
REQ-030 a=0xFFFF, b=0x0001, sub=0 -> s=0x0000, co=1, ovf=0; then a=0x7FFF, b=0x0001 -> s=0x8000, co=0, ovf=1.
REQ-031 a=0x0005, b=0x0007, sub=1 -> s=0xFFFE, co=0 (borrow), ovf=0; a=0x8000, b=0x0001, sub=1 -> s=0x7FFF, co=1, ovf=1.
REQ-032 out_ready=0 for 10 cycles in DONE -> s/co/ovf stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-033 rst pulsed asynchronously mid-RUN (after 2 chunks) -> outputs zero immediately, no out_valid; next op a=0x1234, b=0x1111 -> s=0x2345.
REQ-034 Re-run with CHUNK=16 (NCHUNK=1) and CHUNK=1 (16 cycles) -> a=0xFFFF+0x0001 gives s=0x0000, co=1 with latency 1 and 16 respectively.
